mat_mult_pipe: RTL

- Parametrised successor to the fixed 6x6 matrix multiplier. Computes C = A*B, or C += A*B, for NxN signed matrices.
- Uses outer-product accumulation: on step k, column k of A is multiplied by row k of B across an NxN pipelined multiplier array, and the results are summed into per-element accumulators.
- Adds a start/busy/done handshake, an accumulate mode, selectable saturation and a sticky overflow flag.
- Sits between the operand buffers and the result readback logic in the matrix datapath.

---
 rtl/mat_mult_pkg.sv | 58 +++++
 rtl/mat_mult_pipe_if.sv | 25 ++
 rtl/mat_mult_pipe_mult.sv | 33 +++
 rtl/mat_mult_pipe.sv | 157 +++++++++++++++
 4 files changed

// File: rtl/mat_mult_pkg.sv
// Shared types and arithmetic helpers for the pipelined NxN matrix multiplier.
// sat_add works on a wide signed scratch width so one function serves any ACC_W.
package mat_mult_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } state_t;

  localparam int N_DEFAULT = 6;
  localparam int K_W       = $clog2(N_DEFAULT);
  localparam int CALC_W    = 64;

  function automatic int k_width(input int n);
    return (n > 2) ? $clog2(n) : 1;
  endfunction

  // Returns {ovf, sum}; the product is narrowed to acc_w+1 bits before the add,
  // and a product that cannot fit in acc_w counts as overflow on its own.
  function automatic logic [CALC_W:0] sat_add(
    input logic signed [CALC_W-1:0] acc,
    input logic signed [CALC_W-1:0] prod,
    input logic                     sat,
    input int                       acc_w
  );
    logic signed [CALC_W-1:0] max_v;
    logic signed [CALC_W-1:0] min_v;
    logic signed [CALC_W-1:0] prod_t;
    logic signed [CALC_W-1:0] sum;
    logic signed [CALC_W-1:0] res;
    logic                     p_ovf;
    logic                     s_ovf;
    int                       sh_p;
    int                       sh_s;
    max_v  = (64'sd1 <<< (acc_w - 1)) - 64'sd1;
    min_v  = -max_v - 64'sd1;
    sh_p   = CALC_W - acc_w - 1;
    sh_s   = CALC_W - acc_w;
    prod_t = (prod <<< sh_p) >>> sh_p;
    sum    = acc + prod_t;
    p_ovf  = (prod > max_v) || (prod < min_v);
    s_ovf  = (sum > max_v) || (sum < min_v);
    res    = sum;
    if (sat) begin
      if (s_ovf) begin
        res = sum[CALC_W-1] ? min_v : max_v;
      end else if (p_ovf) begin
        res = prod[CALC_W-1] ? min_v : max_v;
      end
    end else begin
      res = (sum <<< sh_s) >>> sh_s;
    end
    return {p_ovf | s_ovf, res};
  endfunction

endpackage

// File: rtl/mat_mult_pipe_if.sv
// Operand/result bundle between the operand buffers, the multiplier and readback.
interface mat_mult_pipe_if #(
  parameter int N      = 6,
  parameter int DATA_W = 27,
  parameter int ACC_W  = 27
);
  logic                  start;
  logic                  acc_mode;
  logic [N*N*DATA_W-1:0] a_in;
  logic [N*N*DATA_W-1:0] b_in;
  logic                  busy;
  logic                  done;
  logic [N*N*ACC_W-1:0]  result;
  logic                  ovf;

  modport master (
    output start, acc_mode, a_in, b_in,
    input  busy, done, result, ovf
  );

  modport slave (
    input  start, acc_mode, a_in, b_in,
    output busy, done, result, ovf
  );
endinterface

// File: rtl/mat_mult_pipe_mult.sv
// NxN array of signed multipliers followed by MULT_LAT register stages.
// Element gi multiplies a_col[gi/N] by b_row[gi%N]; pure datapath.
module mult_array_p #(
  parameter int N        = 6,
  parameter int DATA_W   = 27,
  parameter int MULT_LAT = 3
) (
  input  logic                       clk,
  input  logic                       en,
  input  logic signed [DATA_W-1:0]   a_col [N],
  input  logic signed [DATA_W-1:0]   b_row [N],
  output logic signed [2*DATA_W-1:0] prod  [N*N]
);

  genvar gi;
  generate
    for (gi = 0; gi < N*N; gi++) begin : g_mul
      logic signed [2*DATA_W-1:0] stage_reg [MULT_LAT];

      always_ff @(posedge clk) begin
        if (en) begin
          stage_reg[0] <= a_col[gi / N] * b_row[gi % N];
        end
        for (int s = 1; s < MULT_LAT; s++) begin
          stage_reg[s] <= stage_reg[s-1];
        end
      end

      assign prod[gi] = stage_reg[MULT_LAT-1];
    end
  endgenerate

endmodule

// File: rtl/mat_mult_pipe.sv
// Outer-product NxN matrix multiplier: step k feeds column k of A and row k of B
// into the multiplier array and sums the products into per-element accumulators.
module mat_mult_pipe #(
  parameter int N        = 6,
  parameter int DATA_W   = 27,
  parameter int ACC_W    = 27,
  parameter int MULT_LAT = 3,
  parameter int SAT      = 1
) (
  input logic           clk,
  input logic           rst_n,
  mat_mult_pipe_if.slave bus
);
  import mat_mult_pkg::*;

  localparam int KW = k_width(N);

  state_t                     state_reg;
  state_t                     state_next;
  logic [KW-1:0]              k_reg;
  logic [KW-1:0]              k_next;
  logic [MULT_LAT-1:0]        vpipe_reg;
  logic                       ovf_reg;
  logic                       busy_reg;
  logic                       accept;
  logic                       issue;
  logic                       valid_out;
  logic [N*N-1:0]             ovf_vec;
  logic signed [DATA_W-1:0]   a_reg [N*N];
  logic signed [DATA_W-1:0]   b_reg [N*N];
  logic signed [DATA_W-1:0]   a_col [N];
  logic signed [DATA_W-1:0]   b_row [N];
  logic signed [2*DATA_W-1:0] prod  [N*N];

  assign valid_out = vpipe_reg[MULT_LAT-1];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg <= IDLE;
      k_reg     <= '0;
      vpipe_reg <= '0;
      ovf_reg   <= 1'b0;
      busy_reg  <= 1'b0;
    end else begin
      state_reg    <= state_next;
      k_reg        <= k_next;
      vpipe_reg[0] <= issue;
      for (int i = 1; i < MULT_LAT; i++) begin
        vpipe_reg[i] <= vpipe_reg[i-1];
      end
      // busy rises one cycle into the run and drops as DONE is entered
      busy_reg <= ((state_reg == ISSUE) || (state_reg == DRAIN)) && (state_next != DONE);
      if (accept) begin
        ovf_reg <= 1'b0;
      end else if (valid_out && (|ovf_vec)) begin
        ovf_reg <= 1'b1;
      end
    end
  end

  always_comb begin
    state_next = state_reg;
    k_next     = k_reg;
    accept     = 1'b0;
    issue      = 1'b0;
    case (state_reg)
      IDLE: begin
        if (bus.start) begin
          accept     = 1'b1;
          k_next     = '0;
          state_next = ISSUE;
        end
      end
      ISSUE: begin
        issue = 1'b1;
        if (k_reg == KW'(N-1)) begin
          k_next     = '0;
          state_next = DRAIN;
        end else begin
          k_next = k_reg + 1'b1;
        end
      end
      DRAIN: begin
        if (vpipe_reg == '0) begin
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Operands are frozen at acceptance so a_in/b_in may change during the run.
  always_ff @(posedge clk) begin
    if (accept) begin
      for (int i = 0; i < N*N; i++) begin
        a_reg[i] <= bus.a_in[i*DATA_W +: DATA_W];
        b_reg[i] <= bus.b_in[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    for (int r = 0; r < N; r++) begin
      a_col[r] = a_reg[r*N + int'(k_reg)];
      b_row[r] = b_reg[int'(k_reg)*N + r];
    end
  end

  mult_array_p #(
    .N        (N),
    .DATA_W   (DATA_W),
    .MULT_LAT (MULT_LAT)
  ) u_mult (
    .clk   (clk),
    .en    (issue),
    .a_col (a_col),
    .b_row (b_row),
    .prod  (prod)
  );

  genvar gi;
  generate
    for (gi = 0; gi < N*N; gi++) begin : g_acc
      logic signed [ACC_W-1:0] acc_reg;
      logic [CALC_W:0]         add_res;
      logic                    unused_hi;

      assign add_res = sat_add({{(CALC_W-ACC_W){acc_reg[ACC_W-1]}}, acc_reg},
                               {{(CALC_W-2*DATA_W){prod[gi][2*DATA_W-1]}}, prod[gi]},
                               SAT != 0, ACC_W);
      assign unused_hi = ^add_res[CALC_W-1:ACC_W];
      assign ovf_vec[gi] = add_res[CALC_W];

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          acc_reg <= '0;
        end else if (accept && !bus.acc_mode) begin
          acc_reg <= '0;
        end else if (valid_out) begin
          acc_reg <= add_res[ACC_W-1:0];
        end
      end

      assign bus.result[gi*ACC_W +: ACC_W] = acc_reg;
    end
  endgenerate

  assign bus.busy = busy_reg;
  assign bus.done = (state_reg == DONE);
  assign bus.ovf  = ovf_reg;

endmodule
